prog_loader: RTL and testbench

Hardware program-image loader for the single-cycle RISC-V core. It receives a length-prefixed little-endian byte stream over a valid/ready interface and assembles 32-bit words. It writes each word into the instruction and data memories, which share one write port and the same image. It holds the core in reset until the whole image is written, and it replaces the simulation-only memory preload for board bring-up and for co-simulation with a host.

---
 rtl/prog_loader.sv | 144 ++++++++++++++
 tb/tb_prog_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-image loader: takes a length-prefixed little-endian byte stream and writes
// 32-bit words into the shared IM/DM write port, holding the core in reset until done.
module prog_loader #(
  parameter int unsigned MEM_WORDS = 100,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] count_q, count_d;
  logic [23:0] buf_q, buf_d;
  logic [31:0] wordIdx_q, wordIdx_d;
  logic        memWe_q, memWe_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic        cpuRst_q, cpuRst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        fire;
  logic [31:0] hdrCount;

  assign in_ready = ~rst & ((state_q == S_HDR) | (state_q == S_DATA));
  assign fire     = in_valid & in_ready;
  // Bytes arrive LSB first, so each new byte shifts in at the top.
  assign hdrCount = {in_data, count_q[31:8]};

  always_comb begin
    state_d    = state_q;
    byteCnt_d  = byteCnt_q;
    count_d    = count_q;
    buf_d      = buf_q;
    wordIdx_d  = wordIdx_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    cpuRst_d   = cpuRst_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_HDR: begin
        if (fire) begin
          count_d   = hdrCount;
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            wordIdx_d = 32'd0;
            if (hdrCount == 32'd0) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              cpuRst_d = 1'b0;
            end else if (hdrCount > 32'(MEM_WORDS)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            memWdata_d = {in_data, buf_q};
            memAddr_d  = BASE_ADDR + (wordIdx_q << 2);
            memWe_d    = 1'b1;
            state_d    = S_WRITE;
          end else begin
            buf_d = {in_data, buf_q[23:8]};
          end
        end
      end
      S_WRITE: begin
        memWe_d = 1'b0;
        // Hold word_idx at N-1 on the final word so it never reaches N.
        if ((wordIdx_q + 32'd1) == count_q) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          cpuRst_d = 1'b0;
        end else begin
          wordIdx_d = wordIdx_q + 32'd1;
          state_d   = S_DATA;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR;
      byteCnt_q  <= 2'd0;
      count_q    <= 32'd0;
      buf_q      <= 24'd0;
      wordIdx_q  <= 32'd0;
      memWe_q    <= 1'b0;
      memAddr_q  <= 32'd0;
      memWdata_q <= 32'd0;
      cpuRst_q   <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      count_q    <= count_d;
      buf_q      <= buf_d;
      wordIdx_q  <= wordIdx_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      cpuRst_q   <= cpuRst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign cpu_rst   = cpuRst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: header decode, word assembly,
// write timing, empty/oversize images and reset in the middle of a load.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  prog_loader #(.MEM_WORDS(100), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Every high mem_we cycle is logged once, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one byte after `gap` idle cycles and waits (bounded) for its transfer.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    logic accepted;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'hxx;
    checkOutput("byteAccepted", {31'd0, accepted}, 32'd1);
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(negedge clk);
    checkOutput("rstInReady", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  logic [7:0] basicImg[12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'hEF, 8'hBE, 8'hAD, 8'hDE};
  int         gapTbl[12]   = '{0, 2, 0, 1, 3, 0, 1, 0, 0, 2, 0, 4};

  initial begin
    int base;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;

    // Reset held two cycles with a byte offered
    repeat (2) begin
      @(negedge clk);
      checkOutput("rstReady", {31'd0, in_ready}, 32'd0);
    end
    checkOutput("rstWe", {31'd0, mem_we}, 32'd0);
    checkOutput("rstCpuRst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    checkOutput("rstAddr", mem_addr, 32'd0);
    checkOutput("rstWdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;

    // Basic load, back to back; byte 8 is held through the WRITE bubble
    base = wrAddr.size();
    for (int i = 0; i < 12; i++) applyStimulus(basicImg[i], 0);
    @(negedge clk);
    checkOutput("lastWeHigh", {31'd0, mem_we}, 32'd1);
    checkOutput("lastDoneLow", {31'd0, done}, 32'd0);
    checkOutput("writeReady", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("lastWeLow", {31'd0, mem_we}, 32'd0);
    checkOutput("doneHigh", {31'd0, done}, 32'd1);
    checkOutput("cpuRstLow", {31'd0, cpu_rst}, 32'd0);
    checkOutput("doneReady", {31'd0, in_ready}, 32'd0);
    checkOutput("basicCount", wrAddr.size() - base, 32'd2);
    if (wrAddr.size() - base == 2) begin
      checkOutput("basicAddr0", wrAddr[base], 32'h0);
      checkOutput("basicData0", wrData[base], 32'h00000013);
      checkOutput("basicAddr1", wrAddr[base+1], 32'h4);
      checkOutput("basicData1", wrData[base+1], 32'hDEADBEEF);
    end

    // Same image with gaps in in_valid
    doReset();
    checkOutput("reloadDoneClr", {31'd0, done}, 32'd0);
    base = wrAddr.size();
    for (int i = 0; i < 12; i++) applyStimulus(basicImg[i], gapTbl[i]);
    repeat (2) @(negedge clk);
    checkOutput("gapDone", {31'd0, done}, 32'd1);
    checkOutput("gapCount", wrAddr.size() - base, 32'd2);
    if (wrAddr.size() - base == 2) begin
      checkOutput("gapAddr0", wrAddr[base], 32'h0);
      checkOutput("gapData0", wrData[base], 32'h00000013);
      checkOutput("gapAddr1", wrAddr[base+1], 32'h4);
      checkOutput("gapData1", wrData[base+1], 32'hDEADBEEF);
    end

    // Empty image
    doReset();
    base = wrAddr.size();
    for (int i = 0; i < 4; i++) applyStimulus(8'h00, 0);
    @(negedge clk);
    checkOutput("emptyDone", {31'd0, done}, 32'd1);
    checkOutput("emptyCpuRst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("emptyReady", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("emptyReadyLater", {31'd0, in_ready}, 32'd0);
    checkOutput("emptyNoWrite", wrAddr.size() - base, 32'd0);

    // N == MEM_WORDS is accepted
    doReset();
    applyStimulus(8'h64, 0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 0);
    @(negedge clk);
    checkOutput("maxErr", {31'd0, err}, 32'd0);
    checkOutput("maxReady", {31'd0, in_ready}, 32'd1);

    // N = 101 is rejected, following data ignored
    doReset();
    base = wrAddr.size();
    applyStimulus(8'h65, 0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 0);
    @(negedge clk);
    checkOutput("overErr", {31'd0, err}, 32'd1);
    checkOutput("overReady", {31'd0, in_ready}, 32'd0);
    checkOutput("overCpuRst", {31'd0, cpu_rst}, 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h30 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("overNoWrite", wrAddr.size() - base, 32'd0);
    checkOutput("overDone", {31'd0, done}, 32'd0);
    checkOutput("overErrSticky", {31'd0, err}, 32'd1);

    // Reset after one word plus two bytes, then a one-word image
    doReset();
    checkOutput("errClrByRst", {31'd0, err}, 32'd0);
    applyStimulus(8'h03, 0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 0);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h66, 0);
    doReset();
    base = wrAddr.size();
    applyStimulus(8'h01, 0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 0);
    applyStimulus(8'h78, 0);
    applyStimulus(8'h56, 0);
    applyStimulus(8'h34, 0);
    applyStimulus(8'h12, 0);
    repeat (2) @(negedge clk);
    checkOutput("midDone", {31'd0, done}, 32'd1);
    checkOutput("midCount", wrAddr.size() - base, 32'd1);
    if (wrAddr.size() - base == 1) begin
      checkOutput("midAddr", wrAddr[base], 32'h0);
      checkOutput("midData", wrData[base], 32'h12345678);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
